// File: rtl/fpu_result_buffer.sv
// Result FIFO behind the fixed-latency FPU pipeline, with credit-based issue
// gating so that every result leaving the pipeline finds a free slot.
module fpu_result_buffer #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             overflow
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg,   wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg,   rd_ptr_next;
    logic [CW-1:0] count_reg,    count_next;
    logic [CW-1:0] reserved_reg, reserved_next;
    logic          overflow_reg, overflow_next;

    logic             full;
    logic             pop;
    logic             push;
    logic             issue_fire;
    logic             credit_dec;
    logic [DEPTH-1:0] wr_en;

    // Everything visible downstream or upstream comes from registered state.
    assign out_valid   = (count_reg != '0);
    assign out_data    = mem[rd_ptr_reg];
    assign count       = count_reg;
    assign overflow    = overflow_reg;
    assign issue_ready = (reserved_reg < FULL_COUNT);

    assign full       = (count_reg == FULL_COUNT);
    assign pop        = out_valid && out_ready;
    assign push       = res_valid && (!full || pop);
    assign issue_fire = issue_valid && issue_ready;
    // Never let a stray pop wrap the credit counter below zero.
    assign credit_dec = pop && (reserved_reg != '0);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        reserved_next = reserved_reg;
        overflow_next = overflow_reg;

        if (push) begin
            wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        case ({issue_fire, credit_dec})
            2'b10:   reserved_next = reserved_reg + 1'b1;
            2'b01:   reserved_next = reserved_reg - 1'b1;
            default: reserved_next = reserved_reg;
        endcase

        // A result with nowhere to go is dropped; only the sticky flag records it.
        if (res_valid && !push) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            reserved_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            reserved_reg <= reserved_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage is not reset; contents are only observable behind out_valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem[i] <= res_data;
            end
        end
    end

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Bench for fpu_result_buffer: directed scenarios plus randomized streaming
// through a 3-stage pipeline, checked against a queue-based reference model.
module tb_fpu_result_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int NOPS  = 1000;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic             issue_ready;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             overflow;

    fpu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: stored results, outstanding credits, sticky error.
    logic [WIDTH-1:0] fifo_q [$];
    int               res_m;
    bit               ovf_m;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("out_valid", 32'(out_valid), 32'(fifo_q.size() != 0));
        if (fifo_q.size() != 0) check("out_data", out_data, fifo_q[0]);
        check("count", 32'(count), 32'(fifo_q.size()));
        check("overflow", 32'(overflow), 32'(ovf_m));
        check("issue_ready", 32'(issue_ready), 32'(res_m < DEPTH));
    endtask

    task automatic model_reset();
        fifo_q.delete();
        res_m = 0;
        ovf_m = 0;
    endtask

    // One clock with the currently driven inputs, then model update and check.
    task automatic tick();
        bit pop_m, push_m, iss_m, dec_m;
        logic [WIDTH-1:0] d;
        pop_m  = (fifo_q.size() != 0) && out_ready;
        push_m = res_valid && ((fifo_q.size() < DEPTH) || pop_m);
        iss_m  = issue_valid && (res_m < DEPTH);
        dec_m  = pop_m && (res_m > 0);
        d      = res_data;
        if (res_valid && !push_m) ovf_m = 1;
        @(posedge clk);
        if (pop_m) void'(fifo_q.pop_front());
        if (push_m) fifo_q.push_back(d);
        res_m = res_m + int'(iss_m) - int'(dec_m);
        #1;
        check_all();
    endtask

    logic [WIDTH-1:0] vals [4];
    logic [WIDTH-1:0] last;
    logic             pv [3];
    logic [WIDTH-1:0] pd [3];
    int               seq_in, seq_out;
    bit               fire;

    initial begin
        vals[0] = 32'h3F80_0000; vals[1] = 32'h4000_0000;
        vals[2] = 32'h4040_0000; vals[3] = 32'h4080_0000;
        rst = 1'b0; issue_valid = 0; res_valid = 0; res_data = '0; out_ready = 0;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_issue_ready", 32'(issue_ready), 1);
        @(negedge clk) rst = 1'b1;

        // Credit exhaustion: the 5th issue must be refused
        issue_valid = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 3) check("exhaust_ready", 32'(issue_ready), 0);
        end
        check("exhaust_5th", 32'(issue_ready), 0);
        issue_valid = 0;
        res_valid = 1;
        for (int i = 0; i < 4; i++) begin
            res_data = vals[i];
            tick();
        end
        res_valid = 0;
        check("full_count", 32'(count), 4);
        check("full_ovf", 32'(overflow), 0);

        // Drain order and credit return
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_%0d", i), out_data, vals[i]);
            tick();
            if (i == 0) check("credit_return", 32'(issue_ready), 1);
        end
        out_ready = 0;
        check("drained", 32'(out_valid), 0);

        // Simultaneous push and pop while full
        issue_valid = 1;
        repeat (4) tick();
        issue_valid = 0;
        res_valid = 1;
        for (int i = 0; i < 4; i++) begin
            res_data = 32'hC000_0000 + 32'(i);
            tick();
        end
        res_data = 32'h4100_0000;
        out_ready = 1;
        tick();
        res_valid = 0;
        check("pushpop_count", 32'(count), 4);
        check("pushpop_ovf", 32'(overflow), 0);
        last = '0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) last = out_data;
            tick();
        end
        check("pushpop_last", last, 32'h4100_0000);
        out_ready = 0;

        // Overflow: sticky, drops the result, leaves contents alone
        issue_valid = 1;
        repeat (4) tick();
        issue_valid = 0;
        res_valid = 1;
        for (int i = 0; i < 4; i++) begin
            res_data = 32'hD000_0000 + 32'(i);
            tick();
        end
        res_data = 32'hDEAD_BEEF;
        tick();
        res_valid = 0;
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count", 32'(count), 4);
        check("ovf_head", out_data, 32'hD000_0000);
        repeat (2) tick();
        check("ovf_sticky", 32'(overflow), 1);

        // Asynchronous reset with count 3 and reserved 4
        out_ready = 1;
        tick();
        out_ready = 0;
        issue_valid = 1;
        tick();
        issue_valid = 0;
        check("pre_rst_count", 32'(count), 3);
        check("pre_rst_ready", 32'(issue_ready), 0);
        #2 rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_count", 32'(count), 0);
        check("arst_overflow", 32'(overflow), 0);
        check("arst_issue_ready", 32'(issue_ready), 1);
        model_reset();
        @(negedge clk) rst = 1'b1;

        // Random streaming through a 3-stage pipeline
        for (int s = 0; s < 3; s++) begin pv[s] = 0; pd[s] = '0; end
        seq_in = 0;
        seq_out = 0;
        for (int cyc = 0; cyc < 20000 && seq_out < NOPS; cyc++) begin
            res_valid   = pv[2];
            res_data    = pd[2];
            issue_valid = (seq_in < NOPS) && ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 1) != 0);
            fire = issue_valid && issue_ready;
            if (out_valid && out_ready) begin
                check("stream_order", out_data, 32'h1000_0000 + 32'(seq_out));
                seq_out++;
            end
            tick();
            pv[2] = pv[1]; pd[2] = pd[1];
            pv[1] = pv[0]; pd[1] = pd[0];
            pv[0] = fire;  pd[0] = 32'h1000_0000 + 32'(seq_in);
            if (fire) seq_in++;
            check("stream_credit_bound",
                  32'((int'(pv[0]) + int'(pv[1]) + int'(pv[2]) + int'(count)) <= DEPTH), 1);
        end
        issue_valid = 0; res_valid = 0; out_ready = 0;
        check("stream_all_out", 32'(seq_out), 32'(NOPS));
        check("stream_no_ovf", 32'(overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
